// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives a handshaked word SRAM, extracts big-endian
// sub-word loads and performs read-modify-write for byte/halfword stores.
module mem_access_unit #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_enable,
  input  logic              mem_rw,
  input  logic [1:0]        mem_size,
  input  logic              mem_se,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic              done,
  output logic              misalign_err,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-3:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  input  logic              sram_ack
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_MERGE, S_WR, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_rw;
  logic              r_se;
  logic [1:0]        r_size;
  logic [1:0]        r_off;
  logic [ADDR_W-3:0] r_addr;
  logic [15:0]       r_sdata;
  logic [31:0]       r_rdata;
  logic [31:0]       r_wdata;
  logic [31:0]       r_load;
  logic              r_misalign;

  logic              w_misaligned;
  logic              w_accept;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_extract;
  logic [31:0]       w_merged;
  logic              w_unused;

  // Size 11 behaves as a word, so mem_size[1] alone identifies word accesses.
  assign w_misaligned = ((mem_size == 2'b01) && addr[0]) ||
                        (mem_size[1] && (addr[1:0] != 2'b00));
  assign w_accept     = (r_state == S_IDLE) && mem_enable && !w_misaligned;
  assign w_unused     = ^addr[31:ADDR_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    stall    = 1'b0;
    done     = 1'b0;
    sram_req = 1'b0;
    sram_we  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !reset) begin
          stall  = 1'b1;
          w_next = (mem_rw && mem_size[1]) ? S_WR : S_RD;
        end
      end
      S_RD: begin
        stall    = 1'b1;
        sram_req = 1'b1;
        if (sram_ack) w_next = r_rw ? S_MERGE : S_DONE;
      end
      S_MERGE: begin
        stall  = 1'b1;
        w_next = S_WR;
      end
      S_WR: begin
        stall    = 1'b1;
        sram_req = 1'b1;
        sram_we  = 1'b1;
        if (sram_ack) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Big-endian lane select straight from the returning SRAM word.
  always_comb begin
    w_byte    = sram_rdata[31:24];
    w_half    = r_off[1] ? sram_rdata[15:0] : sram_rdata[31:16];
    w_extract = sram_rdata;
    case (r_off)
      2'd0:    w_byte = sram_rdata[31:24];
      2'd1:    w_byte = sram_rdata[23:16];
      2'd2:    w_byte = sram_rdata[15:8];
      default: w_byte = sram_rdata[7:0];
    endcase
    if (r_size == 2'b00)      w_extract = {{24{r_se & w_byte[7]}}, w_byte};
    else if (r_size == 2'b01) w_extract = {{16{r_se & w_half[15]}}, w_half};
  end

  always_comb begin
    w_merged = r_rdata;
    if (r_size == 2'b00) begin
      case (r_off)
        2'd0:    w_merged[31:24] = r_sdata[7:0];
        2'd1:    w_merged[23:16] = r_sdata[7:0];
        2'd2:    w_merged[15:8]  = r_sdata[7:0];
        default: w_merged[7:0]   = r_sdata[7:0];
      endcase
    end else if (r_size == 2'b01) begin
      if (r_off[1]) w_merged[15:0]  = r_sdata;
      else          w_merged[31:16] = r_sdata;
    end
  end

  // Request fields are latched at acceptance; the pipeline copies are not trusted afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rw       <= 1'b0;
      r_se       <= 1'b0;
      r_size     <= 2'b00;
      r_off      <= 2'b00;
      r_addr     <= '0;
      r_sdata    <= 16'h0;
      r_rdata    <= 32'h0;
      r_wdata    <= 32'h0;
      r_load     <= 32'h0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= (r_state == S_IDLE) && mem_enable && w_misaligned;
      if (w_accept) begin
        r_rw    <= mem_rw;
        r_se    <= mem_se;
        r_size  <= mem_size;
        r_off   <= addr[1:0];
        r_addr  <= addr[ADDR_W-1:2];
        r_sdata <= store_data[15:0];
        if (mem_rw && mem_size[1]) r_wdata <= store_data;
      end
      if ((r_state == S_RD) && sram_ack) begin
        r_rdata <= sram_rdata;
        if (!r_rw) r_load <= w_extract;
      end
      if (r_state == S_MERGE) r_wdata <= w_merged;
    end
  end

  assign load_data    = r_load;
  assign misalign_err = r_misalign;
  assign sram_addr    = r_addr;
  assign sram_wdata   = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: an SRAM model with programmable wait states,
// an arithmetic reference for load extraction and store merging, and a per-cycle checker.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_enable = 1'b0;
  logic        mem_rw = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic        mem_se = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic [31:0] load_data;
  logic        stall;
  logic        done;
  logic        misalign_err;
  logic        sram_req;
  logic        sram_we;
  logic [6:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ack;

  int          total = 0;
  int          bad = 0;

  logic [31:0] mem [0:127];
  logic        memClear = 1'b1;
  int          ackDelay = 0;
  int          waitCnt = 0;
  logic        strayAck = 1'b0;

  logic        checkEn = 1'b0;
  logic [31:0] expLoad = 32'h0;
  logic        curIsLoad = 1'b0;
  logic [31:0] curLoadVal = 32'h0;
  logic [6:0]  curWaddr = 7'h0;
  logic [31:0] curWdata = 32'h0;

  mem_access_unit #(.ADDR_W(9)) dut (
    .clk(clk), .reset(reset), .mem_enable(mem_enable), .mem_rw(mem_rw),
    .mem_size(mem_size), .mem_se(mem_se), .addr(addr), .store_data(store_data),
    .load_data(load_data), .stall(stall), .done(done), .misalign_err(misalign_err),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ack(sram_ack)
  );

  always #5 clk = ~clk;

  // SRAM model: acknowledges after ackDelay cycles of continuous request.
  assign sram_ack   = (sram_req && (waitCnt >= ackDelay)) || strayAck;
  assign sram_rdata = mem[sram_addr];

  always @(posedge clk or posedge reset) begin
    if (reset)                     waitCnt <= 0;
    else if (sram_req && !sram_ack) waitCnt <= waitCnt + 1;
    else                           waitCnt <= 0;
  end

  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
    end else if (!reset && sram_req && sram_ack && sram_we) begin
      mem[sram_addr] <= sram_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sizeBytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] laneMask(input int nb);
    return (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
  endfunction

  // Big-endian: byte offset k of an n-byte item sits (4-k-n)*8 bits above bit 0.
  function automatic logic [31:0] refLoad(input logic [31:0] w, input logic [1:0] sz,
                                          input logic se, input logic [1:0] off);
    int          nb = sizeBytes(sz);
    int          sh = (4 - int'(off) - nb) * 8;
    logic [31:0] m  = laneMask(nb);
    logic [31:0] v;
    if (nb == 4) sh = 0;
    v = (w >> sh) & m;
    if (se && nb < 4 && v[8 * nb - 1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] refMerge(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off, input logic [31:0] sd);
    int          nb = sizeBytes(sz);
    int          sh = (4 - int'(off) - nb) * 8;
    logic [31:0] m  = laneMask(nb);
    if (nb == 4) return sd;
    return (w & ~(m << sh)) | ((sd & m) << sh);
  endfunction

  // Per-cycle comparison of the outputs that carry data.
  always @(negedge clk) begin
    if (reset) begin
      expLoad = 32'h0;
    end else if (checkEn) begin
      if (done && curIsLoad) expLoad = curLoadVal;
      checkOutput("load_data", load_data, expLoad);
      if (sram_req) checkOutput("sram_addr", {25'h0, sram_addr}, {25'h0, curWaddr});
      if (sram_req && sram_we) checkOutput("sram_wdata", sram_wdata, curWdata);
      if (done) checkOutput("stall_in_done", {31'h0, stall}, 32'h0);
    end
  end

  task automatic applyStimulus(input logic rw, input logic [1:0] sz, input logic se,
                               input logic [31:0] a, input logic [31:0] sd,
                               input int delay, input string tag);
    int         stallCnt = 0;
    int         doneCnt = 0;
    int         reqRises = 0;
    int         cyc = 0;
    int         expStall;
    int         expRises;
    logic       prevReq = 1'b0;
    logic       reqSeen = 1'b0;
    logic [6:0] wa = a[8:2];
    bit         misal = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
    ackDelay   = delay;
    curWaddr   = wa;
    curIsLoad  = !rw && !misal;
    curLoadVal = refLoad(mem[wa], sz, se, a[1:0]);
    curWdata   = refMerge(mem[wa], sz, a[1:0], sd);
    @(posedge clk);
    #1;
    mem_rw = rw; mem_size = sz; mem_se = se; addr = a; store_data = sd; mem_enable = 1'b1;
    if (misal) begin
      @(negedge clk);
      checkOutput({tag, " stall"}, {31'h0, stall}, 32'h0);
      reqSeen = sram_req;
      @(posedge clk);
      #1 mem_enable = 1'b0;
      @(negedge clk);
      checkOutput({tag, " misalign_err"}, {31'h0, misalign_err}, 32'h1);
      reqSeen = reqSeen | sram_req;
      @(negedge clk);
      checkOutput({tag, " misalign_pulse_end"}, {31'h0, misalign_err}, 32'h0);
      reqSeen = reqSeen | sram_req;
      checkOutput({tag, " no_sram_req"}, {31'h0, reqSeen}, 32'h0);
    end else begin
      expStall = (!rw || sz[1]) ? 2 + delay : 4 + 2 * delay;
      expRises = (rw && !sz[1]) ? 2 : 1;
      while (cyc < 60) begin
        @(negedge clk);
        cyc++;
        if (sram_req && !prevReq) reqRises++;
        prevReq = sram_req;
        if (stall) stallCnt++;
        if (done) begin
          doneCnt++;
          mem_enable = 1'b0;
          break;
        end
      end
      mem_enable = 1'b0;
      checkOutput({tag, " done_seen"}, doneCnt, 1);
      checkOutput({tag, " stall_cycles"}, stallCnt, expStall);
      checkOutput({tag, " sram_requests"}, reqRises, expRises);
      @(negedge clk);
      checkOutput({tag, " done_pulse_end"}, {31'h0, done}, 32'h0);
      checkOutput({tag, " stall_after"}, {31'h0, stall}, 32'h0);
      if (rw) checkOutput({tag, " mem_word"}, mem[wa], curWdata);
    end
  endtask

  initial begin
    int cyc;
    #1 reset = 1'b1;
    #2;
    checkOutput("reset load_data", load_data, 32'h0);
    checkOutput("reset stall", {31'h0, stall}, 32'h0);
    checkOutput("reset done", {31'h0, done}, 32'h0);
    checkOutput("reset misalign_err", {31'h0, misalign_err}, 32'h0);
    checkOutput("reset sram_req", {31'h0, sram_req}, 32'h0);
    checkOutput("reset sram_we", {31'h0, sram_we}, 32'h0);
    checkOutput("reset sram_addr", {25'h0, sram_addr}, 32'h0);
    checkOutput("reset sram_wdata", sram_wdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    memClear = 1'b0;
    checkEn = 1'b1;

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, "sw@10");
    checkOutput("pin sw@10 word", mem[4], 32'hDEAD_BEEF);
    applyStimulus(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 0, "lw@10");
    checkOutput("pin lw@10", load_data, 32'hDEAD_BEEF);

    applyStimulus(1'b1, 2'b11, 1'b0, 32'h20, 32'h12F4_5678, 0, "sw11@20");
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 0, "lb@21");
    checkOutput("pin lb@21", load_data, 32'hFFFF_FFF4);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 0, "lbu@21");
    checkOutput("pin lbu@21", load_data, 32'h0000_00F4);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 0, "lh@22");
    checkOutput("pin lh@22", load_data, 32'h0000_5678);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 1, "lb@23");
    checkOutput("pin lb@23", load_data, 32'h0000_0078);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h30, 32'hAABB_CCDD, 0, "sw@30");
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h32, 32'h1234_5611, 0, "sb@32");
    checkOutput("pin sb@32 word", mem[12], 32'hAABB_11DD);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h30, 32'h0000_BEEF, 2, "sh@30");
    checkOutput("pin sh@30 word", mem[12], 32'hBEEF_11DD);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 0, "lh@30");
    checkOutput("pin lh@30", load_data, 32'hFFFF_BEEF);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'hFFFF_FE20, 32'h0, 3, "lw@20 wait3");
    checkOutput("pin lw@20 wait3", load_data, 32'h12F4_5678);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 0, "lw@42");
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h43, 32'h0, 0, "lh@43");
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h41, 32'h5555_5555, 0, "sw@41");
    checkOutput("pin misaligned keeps load_data", load_data, 32'h12F4_5678);
    checkOutput("pin misaligned store no write", mem[16], 32'h0);

    strayAck = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("stray ack stall", {30'h0, stall, done}, 32'h0);
      checkOutput("stray ack req", {31'h0, sram_req}, 32'h0);
    end
    strayAck = 1'b0;

    // Word store that never gets acknowledged, then an asynchronous reset.
    ackDelay = 1000;
    curIsLoad = 1'b0;
    curWaddr = 7'h14;
    curWdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    mem_rw = 1'b1; mem_size = 2'b10; addr = 32'h50; store_data = 32'hCAFE_F00D; mem_enable = 1'b1;
    cyc = 0;
    while (cyc < 10 && !(sram_req && sram_we)) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("reset-mid-WR reached WR", {30'h0, sram_req, sram_we}, 32'h3);
    #2;
    mem_enable = 1'b0;
    reset = 1'b1;
    checkEn = 1'b0;
    #1;
    checkOutput("reset-mid-WR sram_req", {31'h0, sram_req}, 32'h0);
    checkOutput("reset-mid-WR sram_we", {31'h0, sram_we}, 32'h0);
    checkOutput("reset-mid-WR stall", {31'h0, stall}, 32'h0);
    checkOutput("reset-mid-WR done", {31'h0, done}, 32'h0);
    checkOutput("reset-mid-WR load_data", load_data, 32'h0);
    checkOutput("reset-mid-WR sram_addr", {25'h0, sram_addr}, 32'h0);
    checkOutput("reset-mid-WR sram_wdata", sram_wdata, 32'h0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    checkEn = 1'b1;
    checkOutput("abandoned store no write", mem[20], 32'h0);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, "lw@10 after reset");
    checkOutput("pin lw@10 after reset", load_data, 32'hDEAD_BEEF);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] timeout");
  end

endmodule
